// File: rtl/bit_serializer_if.sv
// Parallel-load / serial-out bus between a word producer, the serializer and the bit sink.
// master = word producer side, slave = serializer side.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             flush;
  logic             bit_out;
  logic             bit_valid;
  logic             frame_start;
  logic             busy;
  logic [15:0]      word_count;

  modport master (
    output data_in, load_valid, flush,
    input  load_ready, bit_out, bit_valid, frame_start, busy, word_count
  );

  modport slave (
    input  data_in, load_valid, flush,
    output load_ready, bit_out, bit_valid, frame_start, busy, word_count
  );
endinterface

// File: rtl/bit_serializer.sv
// Word-to-bit serializer with a one-word holding register for gapless streaming; first bit
// appears one clock after the accept edge, and load_ready drops while the holding register is full.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  bit_serializer_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_q, frame_d;
  logic [15:0]      word_count_q, word_count_d;

  logic             load_accept;
  logic [WIDTH-1:0] shifted;
  logic             head;

  // flush takes priority over a same-cycle load, so ready is masked while it is high
  assign load_accept = bus.load_valid && !hold_full_q && !bus.flush;

  always_comb begin
    shifted = '0;
    head    = 1'b0;
    if (MSB_FIRST) begin
      shifted = {shift_q[WIDTH-2:0], 1'b0};
      head    = shift_q[WIDTH-1];
    end else begin
      shifted = {1'b0, shift_q[WIDTH-1:1]};
      head    = shift_q[0];
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    frame_d      = 1'b0;
    word_count_d = word_count_q;

    if (bus.flush) begin
      state_d     = IDLE;
      hold_full_d = 1'b0;
      shift_d     = '0;
      cnt_d       = '0;
    end else begin
      if (load_accept) begin
        hold_d      = bus.data_in;
        hold_full_d = 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            shift_d     = hold_q;
            cnt_d       = CNT_MAX;
            hold_full_d = 1'b0;
            frame_d     = 1'b1;
            state_d     = SHIFT;
          end
        end
        SHIFT: begin
          shift_d = shifted;
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            word_count_d = word_count_q + 16'd1;
            // a word already waiting in hold continues the stream without an idle cycle
            if (hold_full_q) begin
              shift_d     = hold_q;
              cnt_d       = CNT_MAX;
              hold_full_d = 1'b0;
              frame_d     = 1'b1;
            end else begin
              cnt_d   = '0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      frame_q      <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      frame_q      <= frame_d;
      word_count_q <= word_count_d;
    end
  end

  assign bus.load_ready  = !hold_full_q && !bus.flush;
  assign bus.bit_out     = (state_q == SHIFT) ? head : IDLE_BIT;
  assign bus.bit_valid   = (state_q == SHIFT);
  assign bus.frame_start = frame_q;
  assign bus.busy        = (state_q == SHIFT) || hold_full_q;
  assign bus.word_count  = word_count_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first and an LSB-first instance, expected serial
// bits queued when each word is offered and popped as bit_valid cycles appear.
module tb_bit_serializer;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(8)) s0 ();
  bit_serializer_if #(.WIDTH(8)) s1 ();

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(s0)
  );
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut1 (
    .clk(clk), .reset(reset), .bus(s1)
  );

  typedef struct packed {
    logic b;
    logic f;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   run0 = 0;
  int   max_run0 = 0;
  logic [7:0] log1 = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon0();
    if (s0.bit_valid === 1'b1) begin
      run0++;
      if (run0 > max_run0) max_run0 = run0;
      chk("dut0 expected bit pending", 32'(q0.size() > 0), 1);
      if (q0.size() > 0) begin
        exp_t e = q0.pop_front();
        chk("dut0 bit_out", 32'(s0.bit_out), 32'(e.b));
        chk("dut0 frame_start", 32'(s0.frame_start), 32'(e.f));
      end
    end else begin
      run0 = 0;
    end
  endtask

  task automatic mon1();
    if (s1.bit_valid === 1'b1) begin
      log1 = {log1[6:0], s1.bit_out};
      chk("dut1 expected bit pending", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        exp_t e = q1.pop_front();
        chk("dut1 bit_out", 32'(s1.bit_out), 32'(e.b));
        chk("dut1 frame_start", 32'(s1.frame_start), 32'(e.f));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon0();
    mon1();
  endtask

  task automatic push0(input logic [7:0] w, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) q0.push_back('{b: w[i], f: (i == 7)});
  endtask

  task automatic push1(input logic [7:0] w);
    for (int i = 0; i < 8; i++) q1.push_back('{b: w[i], f: (i == 0)});
  endtask

  // Presents a word and returns at the negedge following the accepting edge.
  task automatic send(input bit which, input logic [7:0] w);
    bit acc;
    int n;
    n = 0;
    if (which) begin
      s1.data_in = w; s1.load_valid = 1'b1;
    end else begin
      s0.data_in = w; s0.load_valid = 1'b1;
    end
    do begin
      acc = which ? s1.load_ready : s0.load_ready;
      tick();
      n++;
    end while (!acc && n < 32);
    chk("send accepted", 32'(acc), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    chk("drain queues empty", 32'(q0.size() + q1.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    s0.data_in = '0; s0.load_valid = 1'b0; s0.flush = 1'b0;
    s1.data_in = '0; s1.load_valid = 1'b0; s1.flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset load_ready", 32'(s0.load_ready), 1);
    chk("reset bit_out", 32'(s0.bit_out), 0);
    chk("reset bit_valid", 32'(s0.bit_valid), 0);
    chk("reset frame_start", 32'(s0.frame_start), 0);
    chk("reset busy", 32'(s0.busy), 0);
    chk("reset word_count", 32'(s0.word_count), 0);
    reset = 1'b0;
    tick();

    // single word, MSB first
    max_run0 = 0;
    push0(8'hB4, 8);
    send(0, 8'hB4);
    chk("t1 load_ready while held", 32'(s0.load_ready), 0);
    chk("t1 busy while held", 32'(s0.busy), 1);
    s0.load_valid = 1'b0;
    drain();
    tick();
    chk("t1 idle bit_out", 32'(s0.bit_out), 0);
    chk("t1 idle bit_valid", 32'(s0.bit_valid), 0);
    chk("t1 valid run", 32'(max_run0), 8);
    chk("t1 word_count", 32'(s0.word_count), 1);

    // back-to-back words must stream without a gap
    max_run0 = 0;
    push0(8'hA5, 8);
    push0(8'h3C, 8);
    send(0, 8'hA5);
    chk("t2 load_ready while held", 32'(s0.load_ready), 0);
    send(0, 8'h3C);
    s0.load_valid = 1'b0;
    drain();
    tick();
    chk("t2 gapless run", 32'(max_run0), 16);
    chk("t2 word_count", 32'(s0.word_count), 3);

    // LSB-first instance
    push1(8'h0B);
    send(1, 8'h0B);
    s1.load_valid = 1'b0;
    drain();
    tick();
    chk("t3 lsb bit sequence", 32'(log1), 32'h0000_00D0);
    chk("t3 word_count", 32'(s1.word_count), 1);
    chk("t3 idle bit_valid", 32'(s1.bit_valid), 0);

    // flush during the 4th bit of FF while 00 waits in hold
    push0(8'hFF, 4);
    send(0, 8'hFF);
    send(0, 8'h00);
    s0.load_valid = 1'b0;
    tick();
    tick();
    chk("t4 four bits seen", 32'(q0.size()), 0);
    s0.flush = 1'b1;
    #1;
    chk("t4 load_ready during flush", 32'(s0.load_ready), 0);
    tick();
    s0.flush = 1'b0;
    #1;
    chk("t4 bit_out after flush", 32'(s0.bit_out), 0);
    chk("t4 bit_valid after flush", 32'(s0.bit_valid), 0);
    chk("t4 load_ready after flush", 32'(s0.load_ready), 1);
    chk("t4 busy after flush", 32'(s0.busy), 0);
    repeat (12) tick();
    chk("t4 word_count unchanged", 32'(s0.word_count), 3);

    // asynchronous reset during bit 5 of C3
    push0(8'hC3, 5);
    send(0, 8'hC3);
    s0.load_valid = 1'b0;
    repeat (5) tick();
    chk("t5 five bits seen", 32'(q0.size()), 0);
    chk("t5 busy before reset", 32'(s0.busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5 async bit_valid", 32'(s0.bit_valid), 0);
    chk("t5 async busy", 32'(s0.busy), 0);
    chk("t5 async frame_start", 32'(s0.frame_start), 0);
    chk("t5 async bit_out", 32'(s0.bit_out), 0);
    chk("t5 async load_ready", 32'(s0.load_ready), 1);
    chk("t5 async word_count", 32'(s0.word_count), 0);
    @(negedge clk);
    reset = 1'b0;
    push0(8'h81, 8);
    send(0, 8'h81);
    s0.load_valid = 1'b0;
    drain();
    tick();
    chk("t5 word_count after restart", 32'(s0.word_count), 1);

    // word_count wrap
    force dut0.word_count_d = 16'hFFFF;
    tick();
    release dut0.word_count_d;
    #1;
    chk("t6 preload word_count", 32'(s0.word_count), 32'h0000_FFFF);
    push0(8'h5A, 8);
    send(0, 8'h5A);
    s0.load_valid = 1'b0;
    drain();
    tick();
    chk("t6 word_count wrap", 32'(s0.word_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
